// File: rtl/obi_wb_responder_if.sv
// OBI responder bus bundle: core-facing OBI request/response plus Wishbone classic master signals.
// Latency: none, signal grouping only.
// Backpressure: carried by obi_gnt_o on the OBI side and wb_ack_i on the Wishbone side.
interface obi_wb_responder_if;
   // OBI side
   logic        obi_req_i;
   logic        obi_gnt_o;
   logic [31:0] obi_addr_i;
   logic        obi_we_i;
   logic [3:0]  obi_be_i;
   logic [31:0] obi_wdata_i;
   logic        obi_rvalid_o;
   logic [31:0] obi_rdata_o;
   logic        obi_err_o;
   // Wishbone side
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_addr_o;
   logic [31:0] wb_data_o;
   logic [31:0] wb_data_i;
   logic        wb_ack_i;

   // The responder itself: OBI slave, Wishbone master.
   modport slave (
      input  obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
      output obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
      input  wb_data_i, wb_ack_i
   );

   // The surroundings: the core issuing OBI requests and the memory answering Wishbone cycles.
   modport master (
      output obi_req_i, obi_addr_i, obi_we_i, obi_be_i, obi_wdata_i,
      input  obi_gnt_o, obi_rvalid_o, obi_rdata_o, obi_err_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o,
      output wb_data_i, wb_ack_i
   );
endinterface

// File: rtl/obi_wb_responder.sv
// OBI responder: turns each granted OBI request into one Wishbone classic cycle, with optional timeout.
// Latency: gnt at N, stb at N+1, rvalid one cycle after ack (N+2 for zero wait states) or after timeout.
// Backpressure: gnt only in IDLE, so at most one transaction is outstanding; responses strictly in order.
module obi_wb_responder #(
   parameter int          TIMEOUT_CYCLES = 0,
   parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   obi_wb_responder_if.slave   bus
);

   // Counter is at least one bit wide so a disabled timeout still elaborates cleanly.
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
   localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

   typedef enum logic {IDLE, BUS} state_t;

   state_t        state;
   logic          cyc;
   logic          stb;
   logic          we;
   logic [3:0]    sel;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic          rvalid;
   logic [31:0]   rdata;
   logic          err;
   logic [CW-1:0] tmo_cnt;
   logic          gnt;
   logic          tmo_hit;

   // Address phase is accepted combinationally, but only while no transaction is in flight.
   assign gnt = (state == IDLE) && bus.obi_req_i;

   // Abort when the current BUS cycle is the last one allowed and it carries no ack.
   assign tmo_hit = TMO_EN && (tmo_cnt == TMO_LAST);

   assign bus.obi_gnt_o    = gnt;
   assign bus.obi_rvalid_o = rvalid;
   assign bus.obi_rdata_o  = rdata;
   assign bus.obi_err_o    = err;
   assign bus.wb_cyc_o     = cyc;
   assign bus.wb_stb_o     = stb;
   assign bus.wb_we_o      = we;
   assign bus.wb_sel_o     = sel;
   assign bus.wb_addr_o    = addr;
   assign bus.wb_data_o    = wdata;

   // Transaction FSM: latch request in IDLE, run the Wishbone cycle in BUS, emit a one-cycle response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cyc     <= 1'b0;
         stb     <= 1'b0;
         we      <= 1'b0;
         sel     <= 4'h0;
         addr    <= 32'h0;
         wdata   <= 32'h0;
         rvalid  <= 1'b0;
         rdata   <= 32'h0;
         err     <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         // rvalid is a pulse; rdata/err keep their last values between responses.
         rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (gnt) begin
                  addr    <= bus.obi_addr_i;
                  we      <= bus.obi_we_i;
                  sel     <= bus.obi_be_i;
                  wdata   <= bus.obi_wdata_i;
                  cyc     <= 1'b1;
                  stb     <= 1'b1;
                  tmo_cnt <= '0;
                  state   <= BUS;
               end
            end
            BUS: begin
               if (bus.wb_ack_i) begin
                  // Ack has priority over a timeout expiring in the same cycle.
                  rdata  <= we ? 32'h0 : bus.wb_data_i;
                  err    <= 1'b0;
                  rvalid <= 1'b1;
                  cyc    <= 1'b0;
                  stb    <= 1'b0;
                  state  <= IDLE;
               end else if (tmo_hit) begin
                  rdata  <= ERR_RDATA;
                  err    <= 1'b1;
                  rvalid <= 1'b1;
                  cyc    <= 1'b0;
                  stb    <= 1'b0;
                  state  <= IDLE;
               end else if (TMO_EN) begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_obi_wb_responder.sv
// Directed bench for obi_wb_responder with an 8-cycle timeout and a recognisable error data word.
// Latency: checks cycle-exact gnt/stb/rvalid timing against hand-computed expectations.
// Backpressure: exercises wait states, timeout, back-to-back grants and reset during a bus cycle.
module tb_obi_wb_responder;

   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   err_cnt;

   obi_wb_responder_if bus ();

   obi_wb_responder #(
      .TIMEOUT_CYCLES (8),
      .ERR_RDATA      (ERR_WORD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge so registered outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and confirm it is granted in this same cycle.
   task automatic issue(input string tag, input logic [31:0] a, input logic w,
                        input logic [3:0] be, input logic [31:0] wd);
      bus.obi_req_i   = 1'b1;
      bus.obi_addr_i  = a;
      bus.obi_we_i    = w;
      bus.obi_be_i    = be;
      bus.obi_wdata_i = wd;
      #1;
      check({tag, "_gnt"}, 32'(bus.obi_gnt_o), 32'd1);
   endtask

   initial begin
      int stb_seen;
      vec_cnt = 0;
      err_cnt = 0;
      rst_n           = 1'b0;
      bus.obi_req_i   = 1'b0;
      bus.obi_addr_i  = 32'h0;
      bus.obi_we_i    = 1'b0;
      bus.obi_be_i    = 4'h0;
      bus.obi_wdata_i = 32'h0;
      bus.wb_data_i   = 32'h0;
      bus.wb_ack_i    = 1'b0;

      // ---- Reset state ----
      tick();
      tick();
      check("rst_cyc",    32'(bus.wb_cyc_o), 32'd0);
      check("rst_stb",    32'(bus.wb_stb_o), 32'd0);
      check("rst_rvalid", 32'(bus.obi_rvalid_o), 32'd0);
      check("rst_err",    32'(bus.obi_err_o), 32'd0);
      check("rst_rdata",  bus.obi_rdata_o, 32'h0);
      check("rst_addr",   bus.wb_addr_o, 32'h0);
      check("rst_sel",    32'(bus.wb_sel_o), 32'h0);
      rst_n = 1'b1;
      tick();

      // ---- Read, zero wait states ----
      issue("rd1", 32'h0000_1000, 1'b0, 4'hF, 32'h0);
      tick();                                   // N+1
      bus.obi_req_i = 1'b0;
      check("rd1_stb",  32'(bus.wb_stb_o), 32'd1);
      check("rd1_cyc",  32'(bus.wb_cyc_o), 32'd1);
      check("rd1_addr", bus.wb_addr_o, 32'h0000_1000);
      check("rd1_we",   32'(bus.wb_we_o), 32'd0);
      check("rd1_nognt", 32'(bus.obi_gnt_o), 32'd0);
      bus.wb_ack_i  = 1'b1;
      bus.wb_data_i = 32'h1234_5678;
      tick();                                   // N+2
      bus.wb_ack_i  = 1'b0;
      bus.wb_data_i = 32'h0;
      check("rd1_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
      check("rd1_rdata",  bus.obi_rdata_o, 32'h1234_5678);
      check("rd1_err",    32'(bus.obi_err_o), 32'd0);
      check("rd1_stb_off", 32'(bus.wb_stb_o), 32'd0);
      tick();
      check("rd1_pulse", 32'(bus.obi_rvalid_o), 32'd0);
      check("rd1_hold",  bus.obi_rdata_o, 32'h1234_5678);

      // ---- Write, three wait states ----
      issue("wr", 32'h0000_2004, 1'b1, 4'b0011, 32'hCAFE_F00D);
      bus.wb_data_i = 32'hFFFF_FFFF;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.obi_req_i = 1'b0;
         check("wr_stb",    32'(bus.wb_stb_o), 32'd1);
         check("wr_sel",    32'(bus.wb_sel_o), 32'h3);
         check("wr_data",   bus.wb_data_o, 32'hCAFE_F00D);
         check("wr_we",     32'(bus.wb_we_o), 32'd1);
         check("wr_norv",   32'(bus.obi_rvalid_o), 32'd0);
         if (i == 3) bus.wb_ack_i = 1'b1;
      end
      tick();
      bus.wb_ack_i  = 1'b0;
      check("wr_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
      check("wr_rdata",  bus.obi_rdata_o, 32'h0);
      check("wr_err",    32'(bus.obi_err_o), 32'd0);
      tick();
      check("wr_pulse",  32'(bus.obi_rvalid_o), 32'd0);

      // ---- Back-to-back reads, req held high ----
      issue("b2b_a", 32'h0000_0000, 1'b0, 4'hF, 32'h0);
      tick();
      bus.obi_addr_i = 32'h0000_0004;
      #1;
      check("b2b_a_addr", bus.wb_addr_o, 32'h0000_0000);
      check("b2b_a_nognt", 32'(bus.obi_gnt_o), 32'd0);
      bus.wb_ack_i  = 1'b1;
      bus.wb_data_i = 32'hAAAA_0000;
      tick();
      bus.wb_ack_i  = 1'b0;
      #1;
      check("b2b_a_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
      check("b2b_a_rdata",  bus.obi_rdata_o, 32'hAAAA_0000);
      check("b2b_b_gnt",    32'(bus.obi_gnt_o), 32'd1);
      tick();
      bus.obi_req_i = 1'b0;
      check("b2b_b_norv",  32'(bus.obi_rvalid_o), 32'd0);
      check("b2b_b_addr",  bus.wb_addr_o, 32'h0000_0004);
      bus.wb_ack_i  = 1'b1;
      bus.wb_data_i = 32'hBBBB_0004;
      tick();
      bus.wb_ack_i  = 1'b0;
      check("b2b_b_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
      check("b2b_b_rdata",  bus.obi_rdata_o, 32'hBBBB_0004);
      tick();
      check("b2b_b_pulse",  32'(bus.obi_rvalid_o), 32'd0);

      // ---- Timeout, ack never arrives ----
      issue("tmo", 32'h0000_3000, 1'b0, 4'hF, 32'h0);
      stb_seen = 0;
      tick();
      bus.obi_req_i = 1'b0;
      for (int i = 0; i < 12 && bus.wb_stb_o; i++) begin
         stb_seen++;
         tick();
      end
      check("tmo_stb_cycles", 32'(stb_seen), 32'd8);
      check("tmo_cyc",    32'(bus.wb_cyc_o), 32'd0);
      check("tmo_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
      check("tmo_err",    32'(bus.obi_err_o), 32'd1);
      check("tmo_rdata",  bus.obi_rdata_o, ERR_WORD);
      issue("tmo_next", 32'h0000_3004, 1'b0, 4'hF, 32'h0);
      tick();
      bus.obi_req_i = 1'b0;
      bus.wb_ack_i  = 1'b1;
      bus.wb_data_i = 32'h0000_3004;
      tick();
      bus.wb_ack_i  = 1'b0;
      check("tmo_next_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
      check("tmo_next_err",    32'(bus.obi_err_o), 32'd0);
      tick();

      // ---- Ack in the last allowed stb cycle ----
      issue("late", 32'h0000_4000, 1'b0, 4'hF, 32'h0);
      for (int i = 0; i < 8; i++) begin
         tick();
         bus.obi_req_i = 1'b0;
         check("late_stb", 32'(bus.wb_stb_o), 32'd1);
      end
      bus.wb_ack_i  = 1'b1;
      bus.wb_data_i = 32'h55AA_55AA;
      tick();
      bus.wb_ack_i  = 1'b0;
      check("late_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
      check("late_err",    32'(bus.obi_err_o), 32'd0);
      check("late_rdata",  bus.obi_rdata_o, 32'h55AA_55AA);

      // ---- Spurious ack while idle ----
      tick();
      bus.wb_ack_i  = 1'b1;
      bus.wb_data_i = 32'h9999_9999;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("spur_norv", 32'(bus.obi_rvalid_o), 32'd0);
         check("spur_cyc",  32'(bus.wb_cyc_o), 32'd0);
      end
      bus.wb_ack_i = 1'b0;
      check("spur_rdata", bus.obi_rdata_o, 32'h55AA_55AA);

      // ---- Reset in the middle of a bus cycle ----
      tick();
      issue("mid", 32'h0000_5000, 1'b0, 4'hF, 32'h0);
      tick();
      bus.obi_req_i = 1'b0;
      check("mid_stb", 32'(bus.wb_stb_o), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_cyc_async", 32'(bus.wb_cyc_o), 32'd0);
      check("mid_stb_async", 32'(bus.wb_stb_o), 32'd0);
      bus.wb_ack_i = 1'b1;
      tick();
      check("mid_norv0", 32'(bus.obi_rvalid_o), 32'd0);
      bus.wb_ack_i = 1'b0;
      rst_n = 1'b1;
      tick();
      check("mid_norv1", 32'(bus.obi_rvalid_o), 32'd0);
      issue("post", 32'h0000_0010, 1'b0, 4'hF, 32'h0);
      tick();
      bus.obi_req_i = 1'b0;
      check("post_addr", bus.wb_addr_o, 32'h0000_0010);
      bus.wb_ack_i  = 1'b1;
      bus.wb_data_i = 32'h0BAD_CAFE;
      tick();
      bus.wb_ack_i  = 1'b0;
      check("post_rvalid", 32'(bus.obi_rvalid_o), 32'd1);
      check("post_rdata",  bus.obi_rdata_o, 32'h0BAD_CAFE);
      check("post_err",    32'(bus.obi_err_o), 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
